serial_adder_fsm: RTL and testbench

//  Bit-serial, LSB-first multi-bit adder built around one 1-bit full-adder stage.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fsm_if.sv | 17 +
 rtl/serial_adder_fsm_fa.sv | 25 ++
 rtl/serial_adder_fsm.sv | 112 +++++++++++
 tb/tb_serial_adder_fsm.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, legal WIDTH range
// and the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // A 1-bit counter is still needed when WIDTH=1 because $clog2(1) is 0.
  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fsm_if.sv
// Operand/result bundle of the serial adder; the requester is the master and the
// adder is the slave.
interface serial_adder_fsm_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/serial_adder_fsm_fa.sv
// One-bit full adder written as a truth-table decode of {A,B,Cin}.
module fulladder_decoder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  always_comb begin
    Sum  = 1'b0;
    Cout = 1'b0;
    case ({A, B, Cin})
      3'b000: begin Sum = 1'b0; Cout = 1'b0; end
      3'b001: begin Sum = 1'b1; Cout = 1'b0; end
      3'b010: begin Sum = 1'b1; Cout = 1'b0; end
      3'b011: begin Sum = 1'b0; Cout = 1'b1; end
      3'b100: begin Sum = 1'b1; Cout = 1'b0; end
      3'b101: begin Sum = 1'b0; Cout = 1'b1; end
      3'b110: begin Sum = 1'b0; Cout = 1'b1; end
      default: begin Sum = 1'b1; Cout = 1'b1; end
    endcase
  end

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial LSB-first adder: one full-adder stage reused WIDTH times, with the
// carry registered between bits and a one-cycle done pulse per result.
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_fsm_if.slave   bus
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_widthCheck
    $error("serial_adder_fsm: WIDTH out of the supported range");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_sumSr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_faSum;
  logic             w_faCout;
  logic             w_accept;
  logic             w_shift;
  logic             w_lastBit;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_sumNext;

  fulladder_decoder u_fa (
    .A    (r_aSr[0]),
    .B    (r_bSr[0]),
    .Cin  (r_carry),
    .Sum  (w_faSum),
    .Cout (w_faCout)
  );

  assign w_lastBit = (r_cnt == LAST_CNT);
  // Shift form rather than a concatenation slice so WIDTH=1 stays legal.
  assign w_sumNext = (r_sumSr >> 1) | (WIDTH'(w_faSum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // The unused encoding falls into the default branch and behaves as IDLE.
  always_comb begin
    w_nextState = ST_IDLE;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_busy      = 1'b1;
        w_shift     = 1'b1;
        w_nextState = w_lastBit ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_accept    = bus.start;
        w_nextState = bus.start ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        w_accept    = bus.start;
        w_nextState = bus.start ? ST_SHIFT : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aSr   <= '0;
      r_bSr   <= '0;
      r_sumSr <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_aSr   <= bus.a;
      r_bSr   <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_aSr   <= r_aSr >> 1;
      r_bSr   <= r_bSr >> 1;
      r_sumSr <= w_sumNext;
      r_carry <= w_faCout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_lastBit) begin
        r_sum  <= w_sumNext;
        r_cout <= w_faCout;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm: WIDTH=8 instance for the main scenarios
// plus a WIDTH=1 instance for the single-bit corner.
module tb_serial_adder_fsm;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_adder_fsm_if #(.WIDTH(8)) bus8 ();
  serial_adder_fsm_if #(.WIDTH(1)) bus1 ();

  serial_adder_fsm #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_fsm #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Presents operands at a falling edge and holds start across exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = cv;
    bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
  endtask

  // Counts falling edges after the accepting edge until done, bounded to 40.
  task automatic waitDone(output int cycles, output int busyCycles);
    bit seen;
    seen       = 1'b0;
    cycles     = 0;
    busyCycles = 0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus8.busy) busyCycles++;
      if (bus8.done) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] expSum, input logic expCout);
    int n, bc;
    applyStimulus(av, bv, cv);
    waitDone(n, bc);
    checkOutput({tag, "_sum"},  64'(bus8.sum),  64'(expSum));
    checkOutput({tag, "_cout"}, 64'(bus8.cout), 64'(expCout));
  endtask

  initial begin
    int n, bc, doneCnt;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] model;
    checks = 0;
    errors = 0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(bus8.busy), 64'd0);
    checkOutput("rst_done", 64'(bus8.done), 64'd0);
    checkOutput("rst_sum",  64'(bus8.sum),  64'd0);
    checkOutput("rst_cout", 64'(bus8.cout), 64'd0);
    rst = 1'b0;

    // Basic timing and result.
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    waitDone(n, bc);
    checkOutput("lat_cycles", 64'(n),  64'd9);
    checkOutput("lat_busy",   64'(bc), 64'd8);
    checkOutput("t1_sum",  64'(bus8.sum),  64'h96);
    checkOutput("t1_cout", 64'(bus8.cout), 64'd0);
    @(negedge clk);
    checkOutput("t1_done_pulse", 64'(bus8.done), 64'd0);

    runOp("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    runOp("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Stray start in the middle of SHIFT must be ignored.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    doneCnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus8.a = 8'h11; bus8.start = 1'b1;
      end else if (i == 4) begin
        bus8.start = 1'b0; bus8.a = 8'h0F;
      end
      if (bus8.done) doneCnt++;
    end
    checkOutput("midstart_dones", 64'(doneCnt),   64'd1);
    checkOutput("midstart_sum",   64'(bus8.sum),  64'h10);
    checkOutput("midstart_cout",  64'(bus8.cout), 64'd0);

    // Reset in the 4th SHIFT cycle aborts without a done pulse.
    applyStimulus(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 64'(bus8.busy), 64'd0);
    checkOutput("abort_done", 64'(bus8.done), 64'd0);
    checkOutput("abort_sum",  64'(bus8.sum),  64'd0);
    checkOutput("abort_cout", 64'(bus8.cout), 64'd0);
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) doneCnt++;
    end
    checkOutput("abort_nodone", 64'(doneCnt), 64'd0);
    runOp("after_abort", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    // Back-to-back: start held in DONE re-enters SHIFT directly.
    applyStimulus(8'h12, 8'h34, 1'b0);
    waitDone(n, bc);
    checkOutput("b2b_first_sum", 64'(bus8.sum), 64'h46);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    waitDone(n, bc);
    checkOutput("b2b_cycles", 64'(n),         64'd9);
    checkOutput("b2b_busy",   64'(bc),        64'd8);
    checkOutput("b2b_sum",    64'(bus8.sum),  64'h00);
    checkOutput("b2b_cout",   64'(bus8.cout), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("hold_sum",  64'(bus8.sum),  64'h00);
    checkOutput("hold_cout", 64'(bus8.cout), 64'd1);
    checkOutput("hold_busy", 64'(bus8.busy), 64'd0);

    // WIDTH=1 instance: all operand combinations, done two cycles after start.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      bit seen;
      v = 3'(k);
      @(negedge clk);
      bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0]; bus1.start = 1'b1;
      @(posedge clk);
      #1 bus1.start = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 10) begin
        @(negedge clk);
        n++;
        if (bus1.done) seen = 1'b1;
      end
      checkOutput($sformatf("w1_%0d_cycles", k), 64'(n), 64'd2);
      checkOutput($sformatf("w1_%0d_result", k), 64'({bus1.cout, bus1.sum}),
                  64'(v[2]) + 64'(v[1]) + 64'(v[0]));
    end

    // Random operations against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      runOp($sformatf("rnd%0d", k), ra, rb, rc, model[7:0], model[8]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
